// File: rtl/ball_pkg.sv
// Shared types, constants and helpers for the bouncing-ball controller.
// Holds the FSM state encoding, reset defaults, radius limits and the per-axis move/reflect/clamp step.
package ball_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } ball_state_e;

    // The default screen size. The reset position is the centre of whatever size the top is built with.
    localparam int H_ACTIVE_DEF = 800;
    localparam int V_ACTIVE_DEF = 600;

    localparam logic [2:0] RADIUS_RST = 3'd2;
    localparam logic [2:0] RADIUS_MIN = 3'd1;
    localparam logic [2:0] RADIUS_MAX = 3'd7;

    typedef struct packed {
        logic [10:0] pos;
        logic        hit_lo;
        logic        hit_hi;
    } axis_t;

    function automatic logic [2:0] next_radius(input logic [2:0] r);
        return (r >= RADIUS_MAX) ? RADIUS_MIN : r + 3'd1;
    endfunction

    // One axis step. The move is reflected against the old radius. A reflection fires as soon as the
    // ball edge reaches the wall, not only when it passes the wall. The result is then clamped
    // into the range allowed by the new radius, so a radius change alone never raises a hit flag.
    function automatic axis_t axis_move(
        input logic [10:0]        pos,
        input logic signed [11:0] step,
        input logic signed [11:0] r_old,
        input logic signed [11:0] r_new,
        input logic signed [11:0] last,
        input logic               en
    );
        axis_t              res;
        logic signed [11:0] nxt;
        logic signed [11:0] p;
        nxt        = $signed({1'b0, pos}) + (en ? step : 12'sd0);
        res.hit_lo = en && (step < 12'sd0) && (nxt - r_old <= 12'sd0);
        res.hit_hi = en && (step > 12'sd0) && (nxt + r_old >= last);
        if (res.hit_lo)
            p = r_old;
        else if (res.hit_hi)
            p = last - r_old;
        else
            p = nxt;
        if (p < r_new)
            p = r_new;
        else if (p > last - r_new)
            p = last - r_new;
        res.pos = 11'(p);
        return res;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator. It produces a one-cycle pulse one clock after the counters are seen at the
// first blanking line (vcounter == V_ACTIVE, hcounter == 0).
module frame_tick_gen #(
    parameter int V_ACTIVE = 600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] vcounter,
    input  logic [11:0] hcounter,
    output logic        tick
);

    logic match;
    logic match_q;

    assign match = (vcounter == 11'(V_ACTIVE)) && (hcounter == 12'd0);

    // The edge register stops a stalled counter from producing more than one tick per frame.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            match_q <= match;
            tick    <= match & ~match_q;
        end
    end

endmodule

// File: rtl/ball_ctrl.sv
// Bouncing-ball position and radius controller. All motion and radius updates happen once per frame tick.
// Optional macro BALL_GRAVITY_EN replaces the constant vertical step with an accelerating signed speed.
module ball_ctrl
    import ball_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int STEP     = 2,
    parameter int R_SHIFT  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] vcounter,
    input  logic [11:0] hcounter,
    input  logic        start,
    input  logic        pause,
    input  logic        radius_up,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic [2:0]  radius,
    output logic        moving,
    output logic        bounce
);

    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic signed [11:0] X_LAST = 12'(H_ACTIVE - 1);
    localparam logic signed [11:0] Y_LAST = 12'(V_ACTIVE - 1);
    localparam logic [10:0]        X_RST  = 11'(H_ACTIVE / 2);
    localparam logic [10:0]        Y_RST  = 11'(V_ACTIVE / 2);

    logic tick;

    frame_tick_gen #(
        .V_ACTIVE(V_ACTIVE)
    ) u_frame_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .vcounter(vcounter),
        .hcounter(hcounter),
        .tick    (tick)
    );

    ball_state_e state;
    ball_state_e state_nxt;

    // NOTE: assigning a default before the case keeps every path assigned, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_RUN;
            ST_RUN:    if (pause) state_nxt = ST_PAUSED;
            ST_PAUSED: if (!pause) state_nxt = ST_RUN;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            moving <= 1'b0;
        end else begin
            state  <= state_nxt;
            moving <= (state_nxt == ST_RUN);
        end
    end

    logic               pending;
    logic [2:0]         radius_nxt;
    logic signed [11:0] r_old;
    logic signed [11:0] r_new;
    logic               running;
    logic               dx_neg;
    logic signed [11:0] step_x;
    logic signed [11:0] step_y;
    axis_t              ax;
    axis_t              ay;

    assign radius_nxt = pending ? next_radius(radius) : radius;
    assign r_old      = $signed({9'd0, radius} << R_SHIFT);
    assign r_new      = $signed({9'd0, radius_nxt} << R_SHIFT);
    assign running    = tick && (state == ST_RUN);
    assign step_x     = dx_neg ? -STEP_S : STEP_S;

    assign ax = axis_move(ball_x, step_x, r_old, r_new, X_LAST, running);
    assign ay = axis_move(ball_y, step_y, r_old, r_new, Y_LAST, running);

    // A radius request that arrives on the tick cycle becomes pending for the following tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ball_x  <= X_RST;
            ball_y  <= Y_RST;
            radius  <= RADIUS_RST;
            pending <= 1'b0;
            dx_neg  <= 1'b0;
            bounce  <= 1'b0;
        end else if (tick) begin
            ball_x  <= ax.pos;
            ball_y  <= ay.pos;
            radius  <= radius_nxt;
            pending <= radius_up;
            if (ax.hit_lo)
                dx_neg <= 1'b0;
            else if (ax.hit_hi)
                dx_neg <= 1'b1;
            bounce  <= ax.hit_lo | ax.hit_hi | ay.hit_lo | ay.hit_hi;
        end else begin
            pending <= pending | radius_up;
            bounce  <= 1'b0;
        end
    end

`ifdef BALL_GRAVITY_EN
    logic signed [4:0] vy;

    assign step_y = {{7{vy[4]}}, vy};

    // The speed builds up while the ball falls and is mirrored at the floor or ceiling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vy <= 5'sd0;
        end else if (running) begin
            if (ay.hit_lo || ay.hit_hi)
                vy <= -vy;
            else if (vy != 5'sd15)
                vy <= vy + 5'sd1;
        end
    end
`else
    logic dy_neg;

    assign step_y = dy_neg ? -STEP_S : STEP_S;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dy_neg <= 1'b0;
        end else if (tick) begin
            if (ay.hit_lo)
                dy_neg <= 1'b0;
            else if (ay.hit_hi)
                dy_neg <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl. A default-size instance covers motion, walls, radius, pause and reset.
// A square 103x103 instance reaches exact corners.
module tb_ball_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] vc_main = 11'd0;
    logic [10:0] vc_corner = 11'd0;
    logic [11:0] hcounter = 12'd5;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        radius_up = 1'b0;

    logic [10:0] bx, by, cx, cy;
    logic [2:0]  rad, crad;
    logic        moving, bounce, cmoving, cbounce;

    int n_checks = 0;
    int n_fail = 0;
    int bcnt = 0;
    int cbcnt = 0;

    always #5 clk = ~clk;

    ball_ctrl u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vcounter (vc_main),
        .hcounter (hcounter),
        .start    (start),
        .pause    (pause),
        .radius_up(radius_up),
        .ball_x   (bx),
        .ball_y   (by),
        .radius   (rad),
        .moving   (moving),
        .bounce   (bounce)
    );

    ball_ctrl #(
        .H_ACTIVE(103),
        .V_ACTIVE(103)
    ) u_corner (
        .clk      (clk),
        .rst_n    (rst_n),
        .vcounter (vc_corner),
        .hcounter (hcounter),
        .start    (start),
        .pause    (1'b0),
        .radius_up(1'b0),
        .ball_x   (cx),
        .ball_y   (cy),
        .radius   (crad),
        .moving   (cmoving),
        .bounce   (cbounce)
    );

    // Count the cycles in which each bounce output is high.
    always @(negedge clk) begin
        if (bounce)  bcnt++;
        if (cbounce) cbcnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One frame boundary. Returns on the negedge just after the tick-cycle update.
    task automatic frame(input bit corner, input bit ru_on_tick);
        @(negedge clk);
        if (corner) vc_corner = 11'd103;
        else        vc_main   = 11'd600;
        hcounter = 12'd0;
        @(negedge clk);
        vc_main   = 11'd0;
        vc_corner = 11'd0;
        hcounter  = 12'd5;
        radius_up = ru_on_tick;
        @(negedge clk);
        radius_up = 1'b0;
    endtask

    task automatic press_radius();
        @(negedge clk) radius_up = 1'b1;
        @(negedge clk) radius_up = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_x", bx, 400);
        check("rst_y", by, 300);
        check("rst_radius", rad, 2);
        check("rst_moving", moving, 0);
        check("rst_bounce", bounce, 0);
        rst_n = 1'b1;

        frame(0, 0);
        check("idle_hold_x", bx, 400);

        pulse_start();
        check("start_moving", moving, 1);

        repeat (10) frame(0, 0);
        check("ten_ticks_x", bx, 420);
        check("ten_ticks_y", by, 320);
        check("ten_ticks_moving", moving, 1);
        @(negedge clk);
        check("ten_ticks_no_bounce", bcnt, 0);

        pulse_start();
        check("start_in_run_ignored_x", bx, 420);
        check("start_in_run_moving", moving, 1);

        repeat (181) frame(0, 0);
        check("pre_wall_x", bx, 782);
        check("pre_wall_y", by, 485);
        @(negedge clk);
        check("floor_bounce_count", bcnt, 1);

        frame(0, 0);
        check("right_wall_x", bx, 783);
        check("right_wall_y", by, 483);
        check("right_wall_bounce_hi", bounce, 1);
        @(negedge clk);
        check("right_wall_bounce_lo", bounce, 0);
        check("right_wall_bounce_count", bcnt, 2);

        @(negedge clk) pause = 1'b1;
        @(negedge clk);
        check("paused_moving", moving, 0);
        repeat (5) frame(0, 0);
        check("paused_hold_x", bx, 783);
        check("paused_hold_y", by, 483);

        press_radius();
        frame(0, 0);
        check("radius3", rad, 3);
        check("radius3_clamp_x", bx, 775);
        check("radius3_y", by, 483);
        press_radius();
        press_radius();
        frame(0, 0);
        check("double_press_radius4", rad, 4);
        check("radius4_clamp_x", bx, 767);
        for (int i = 5; i <= 7; i++) begin
            press_radius();
            frame(0, 0);
        end
        check("radius7", rad, 7);
        check("radius7_clamp_x", bx, 743);
        press_radius();
        frame(0, 0);
        check("radius_wrap", rad, 1);
        check("radius_wrap_x", bx, 743);
        frame(0, 1);
        check("ru_on_tick_deferred", rad, 1);
        frame(0, 0);
        check("ru_on_tick_applied", rad, 2);
        @(negedge clk);
        check("clamp_no_bounce", bcnt, 2);

        @(negedge clk) pause = 1'b0;
        @(negedge clk);
        check("resume_moving", moving, 1);
        frame(0, 0);
        check("resume_x", bx, 741);
        check("resume_y", by, 481);

        repeat (18) frame(1, 0);
        check("corner_far_x", cx, 86);
        check("corner_far_y", cy, 86);
        @(negedge clk);
        check("corner_far_single_bounce", cbcnt, 1);
        repeat (34) frame(1, 0);
        check("corner_pre_x", cx, 18);
        check("corner_pre_y", cy, 18);
        frame(1, 0);
        check("corner_x", cx, 16);
        check("corner_y", cy, 16);
        @(negedge clk);
        check("corner_single_bounce", cbcnt, 2);
        frame(1, 0);
        check("corner_flip_x", cx, 18);
        check("corner_flip_y", cy, 18);

        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_x", bx, 400);
        check("async_rst_y", by, 300);
        check("async_rst_radius", rad, 2);
        check("async_rst_moving", moving, 0);
        check("async_rst_bounce", bounce, 0);
        @(negedge clk) rst_n = 1'b1;
        frame(0, 0);
        check("post_rst_idle_x", bx, 400);
        pulse_start();
        frame(0, 0);
        check("post_rst_first_tick_x", bx, 402);
        check("post_rst_first_tick_y", by, 302);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
